snoop_bus_arbiter: RTL and testbench
====================================

Name: snoop_bus_arbiter

Overview:
- Shared-bus controller directly downstream of the two processor cores' L1 cache subsystems.
- Arbitrates core bus requests (`req_core`/`grant`) round-robin.
- Broadcasts the owner's coherence operation (BusRd / BusUpgr / BusRdX) to the other core for snooping.
- Returns the snoop result (`cache_hit`, flushed data) to the owner, and services misses and flushes against main memory.

Parameters:
- GRANT_TIMEOUT, 16: maximum cycles one core may hold grant before forced release.
- ADDR_W, 32: bus address width.
- DATA_W, 32: bus data width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_core_0, req_core_1  input  1  bus request from core 0 / core 1
- grant_0, grant_1  output  1  bus grant to core 0 / core 1 (one-hot or zero)
- bus_data_out_0, bus_data_out_1  input  DATA_W  data driven by each core (flush data)
- bus_address_out_0, bus_address_out_1  input  ADDR_W  address driven by each core
- bus_operation_out_0, bus_operation_out_1  input  2  00 BusRd, 01 BusUpgr, 10 BusRdX, 11 BusNoN
- cache_hit_out_0, cache_hit_out_1  input  1  snoop hit reported by each core
- flush_out_0, flush_out_1  input  1  core is flushing a modified line onto the bus
- bus_data_in_0, bus_data_in_1  output  DATA_W  data returned to each core
- bus_address_in_0, bus_address_in_1  output  ADDR_W  snooped address presented to each core
- bus_operation_in_0, bus_operation_in_1  output  2  snooped operation presented to each core
- cache_hit_in_0, cache_hit_in_1  output  1  snoop result returned to owner
- mem_rd_en, mem_wr_en  output  1  main memory read / write strobe
- mem_address  output  ADDR_W  main memory address
- mem_wdata  output  DATA_W  main memory write data
- mem_rdata  input  DATA_W  main memory read data
- mem_ready  input  1  main memory read data valid (read only; writes complete in 1 cycle)

Behaviour:
- Reset (synchronous, on the clk edge while reset=1):
  - State IDLE; grants 0; `last_owner`=1, so core 0 wins the first tie.
  - `bus_data_in_*`=0, `bus_address_in_*`=0, `bus_operation_in_*`=2'b11, `cache_hit_in_*`=0.
  - `mem_rd_en`=`mem_wr_en`=0, `mem_address`=`mem_wdata`=0; tenure counter=0.
  - Reset mid-transaction aborts it with no further memory strobes.
- FSM states: IDLE, SNOOP, MEM, RELEASE.
- IDLE:
  - If exactly one request is high, register grant to that core.
  - If both are high, grant the core != `last_owner`.
  - Grant is visible the cycle after the request; go to SNOOP.
- Forwarding while a grant is held (registered, 1-cycle latency):
  - Non-owner's `bus_address_in`/`bus_operation_in` = owner's `bus_address_out`/`bus_operation_out`.
  - Owner's `bus_operation_in` = 2'b11.
  - With no grant, both `bus_operation_in` = 2'b11.
- SNOOP: waits until the owner's `bus_operation_out` != 11, then one cycle later samples the snooper's `cache_hit_out`/`flush_out`.
  - `cache_hit_in_owner` <= snooper `cache_hit_out`, held until release.
  - If snooper `flush_out`=1:
    - `bus_data_in_owner` <= snooper `bus_data_out`.
    - One-cycle `mem_wr_en` pulse with `mem_address`=owner address, `mem_wdata`=flush data.
    - Go to RELEASE; no memory read.
  - Else if op is BusRd or BusRdX: go to MEM.
  - Else (BusUpgr): go to RELEASE; no memory access.
- MEM:
  - `mem_rd_en`=1 with `mem_address`=owner address until `mem_ready`.
  - On `mem_ready`: `bus_data_in_owner` <= `mem_rdata`; `mem_rd_en` drops the same edge; go to RELEASE.
- RELEASE: hold grant until the owner deasserts `req_core`. Next edge: grant=0, `last_owner`=owner, forwarded op=11, `cache_hit_in`=0, go to IDLE.
- Tenure counter:
  - Increments every cycle a grant is held; cleared in IDLE.
  - Reaching GRANT_TIMEOUT-1 forces RELEASE exit regardless of state, including MEM: `mem_rd_en` drops and no data is returned.
- No back-to-back grant without one IDLE cycle in between. The other core's request, if pending, is granted the cycle after IDLE is entered.
- Requests arriving during a tenure are ignored until IDLE; a request dropped before grant is never granted.
- Both grants are never high simultaneously; memory read and write are never asserted in the same cycle.

Test Plan:
- Reset, then `req_core_0`=`req_core_1`=1 at cycle 0 → `grant_0`=1 at cycle 1. Core 0 drops its request at cycle 6 → `grant_0`=0 at cycle 7, `grant_1`=1 at cycle 8.
- Core 0 issues BusRd at 0x40; core 1 `cache_hit_out`=0 → `bus_operation_in_1`=00 and `bus_address_in_1`=0x40. `mem_rd_en` rises, `mem_ready` follows 3 cycles later with `mem_rdata`=0xDEADBEEF → `bus_data_in_0`=0xDEADBEEF, `cache_hit_in_0`=0.
- Core 0 issues BusRd at 0x40; core 1 hit with `flush_out`=1 and data 0x12345678 → `bus_data_in_0`=0x12345678, `cache_hit_in_0`=1, one `mem_wr_en` pulse (addr 0x40, data 0x12345678), `mem_rd_en` never asserted.
- Core 1 issues BusUpgr at 0x80 → `bus_operation_in_0`=01 and `bus_address_in_0`=0x80; no memory strobes; release on request drop.
- Core 0 holds its request for 40 cycles while core 1 also requests, GRANT_TIMEOUT=16 → `grant_0` drops after 16 granted cycles; `grant_1` is asserted after one IDLE cycle.
- Reset asserted for one cycle during MEM → next edge `mem_rd_en`=0, grants 0, ops 11. A subsequent request from core 0 is granted normally.

Source files
------------

// File: rtl/snoop_bus_arbiter.sv
// Two-core snooping bus controller: round-robin grant, coherence op broadcast,
// snoop result return and main-memory read/flush servicing.
module snoop_bus_arbiter #(
    parameter int unsigned GRANT_TIMEOUT = 16,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_core_0,
    input  logic              req_core_1,
    output logic              grant_0,
    output logic              grant_1,
    input  logic [DATA_W-1:0] bus_data_out_0,
    input  logic [DATA_W-1:0] bus_data_out_1,
    input  logic [ADDR_W-1:0] bus_address_out_0,
    input  logic [ADDR_W-1:0] bus_address_out_1,
    input  logic [1:0]        bus_operation_out_0,
    input  logic [1:0]        bus_operation_out_1,
    input  logic              cache_hit_out_0,
    input  logic              cache_hit_out_1,
    input  logic              flush_out_0,
    input  logic              flush_out_1,
    output logic [DATA_W-1:0] bus_data_in_0,
    output logic [DATA_W-1:0] bus_data_in_1,
    output logic [ADDR_W-1:0] bus_address_in_0,
    output logic [ADDR_W-1:0] bus_address_in_1,
    output logic [1:0]        bus_operation_in_0,
    output logic [1:0]        bus_operation_in_1,
    output logic              cache_hit_in_0,
    output logic              cache_hit_in_1,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned TEN_W = (GRANT_TIMEOUT > 2) ? $clog2(GRANT_TIMEOUT) : 1;

    localparam logic [1:0] OP_UPGR = 2'b01;
    localparam logic [1:0] OP_NON  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_MEM,
        ST_RELEASE
    } state_t;

    state_t             state;
    logic               owner;
    logic               last_owner;
    logic               op_seen;
    logic [TEN_W-1:0]   tenure;
    logic [1:0]         own_op_q;
    logic [ADDR_W-1:0]  own_addr_q;

    // Owner / snooper views of the two core-side interfaces
    logic               own_req;
    logic [1:0]         own_op;
    logic [ADDR_W-1:0]  own_addr;
    logic               snp_hit;
    logic               snp_flush;
    logic [DATA_W-1:0]  snp_data;
    logic               timeout;
    logic               do_release;

    assign own_req   = owner ? req_core_1          : req_core_0;
    assign own_op    = owner ? bus_operation_out_1 : bus_operation_out_0;
    assign own_addr  = owner ? bus_address_out_1   : bus_address_out_0;
    assign snp_hit   = owner ? cache_hit_out_0     : cache_hit_out_1;
    assign snp_flush = owner ? flush_out_0         : flush_out_1;
    assign snp_data  = owner ? bus_data_out_0      : bus_data_out_1;

    assign timeout    = (grant_0 | grant_1) && (tenure == TEN_W'(GRANT_TIMEOUT - 1));
    // An owner may walk away before issuing an op; once an op is in flight it completes
    assign do_release = timeout ||
                        (!own_req && ((state == ST_RELEASE) || ((state == ST_SNOOP) && !op_seen)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            grant_0            <= 1'b0;
            grant_1            <= 1'b0;
            owner              <= 1'b0;
            last_owner         <= 1'b1;
            op_seen            <= 1'b0;
            tenure             <= '0;
            own_op_q           <= OP_NON;
            own_addr_q         <= '0;
            bus_data_in_0      <= '0;
            bus_data_in_1      <= '0;
            bus_address_in_0   <= '0;
            bus_address_in_1   <= '0;
            bus_operation_in_0 <= OP_NON;
            bus_operation_in_1 <= OP_NON;
            cache_hit_in_0     <= 1'b0;
            cache_hit_in_1     <= 1'b0;
            mem_rd_en          <= 1'b0;
            mem_wr_en          <= 1'b0;
            mem_address        <= '0;
            mem_wdata          <= '0;
        end else begin
            mem_wr_en <= 1'b0;

            // Broadcast the owner's request to the other core
            if (grant_0) begin
                bus_address_in_1   <= bus_address_out_0;
                bus_operation_in_1 <= bus_operation_out_0;
                bus_operation_in_0 <= OP_NON;
            end else if (grant_1) begin
                bus_address_in_0   <= bus_address_out_1;
                bus_operation_in_0 <= bus_operation_out_1;
                bus_operation_in_1 <= OP_NON;
            end else begin
                bus_operation_in_0 <= OP_NON;
                bus_operation_in_1 <= OP_NON;
            end

            if (state == ST_IDLE) begin
                tenure  <= '0;
                op_seen <= 1'b0;
                if (req_core_0 && (!req_core_1 || last_owner)) begin
                    grant_0 <= 1'b1;
                    owner   <= 1'b0;
                    state   <= ST_SNOOP;
                end else if (req_core_1) begin
                    grant_1 <= 1'b1;
                    owner   <= 1'b1;
                    state   <= ST_SNOOP;
                end
            end else if (do_release) begin
                grant_0            <= 1'b0;
                grant_1            <= 1'b0;
                last_owner         <= owner;
                bus_operation_in_0 <= OP_NON;
                bus_operation_in_1 <= OP_NON;
                cache_hit_in_0     <= 1'b0;
                cache_hit_in_1     <= 1'b0;
                mem_rd_en          <= 1'b0;
                op_seen            <= 1'b0;
                tenure             <= '0;
                state              <= ST_IDLE;
            end else begin
                tenure <= tenure + TEN_W'(1);
                case (state)
                    ST_SNOOP: begin
                        if (!op_seen) begin
                            if (own_op != OP_NON) begin
                                op_seen    <= 1'b1;
                                own_op_q   <= own_op;
                                own_addr_q <= own_addr;
                            end
                        end else begin
                            // Snooper has seen the forwarded op for one cycle; take its answer
                            if (owner) cache_hit_in_1 <= snp_hit;
                            else       cache_hit_in_0 <= snp_hit;
                            if (snp_flush) begin
                                if (owner) bus_data_in_1 <= snp_data;
                                else       bus_data_in_0 <= snp_data;
                                mem_wr_en   <= 1'b1;
                                mem_address <= own_addr_q;
                                mem_wdata   <= snp_data;
                                state       <= ST_RELEASE;
                            end else if (own_op_q == OP_UPGR) begin
                                state <= ST_RELEASE;
                            end else begin
                                mem_rd_en   <= 1'b1;
                                mem_address <= own_addr_q;
                                state       <= ST_MEM;
                            end
                        end
                    end
                    ST_MEM: begin
                        if (mem_ready) begin
                            if (owner) bus_data_in_1 <= mem_rdata;
                            else       bus_data_in_0 <= mem_rdata;
                            mem_rd_en <= 1'b0;
                            state     <= ST_RELEASE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: expectations queued at stimulus time,
// popped and asserted when the DUT output is sampled.
module tb_snoop_bus_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_core_0, req_core_1;
    logic              grant_0, grant_1;
    logic [DATA_W-1:0] bus_data_out_0, bus_data_out_1;
    logic [ADDR_W-1:0] bus_address_out_0, bus_address_out_1;
    logic [1:0]        bus_operation_out_0, bus_operation_out_1;
    logic              cache_hit_out_0, cache_hit_out_1;
    logic              flush_out_0, flush_out_1;
    logic [DATA_W-1:0] bus_data_in_0, bus_data_in_1;
    logic [ADDR_W-1:0] bus_address_in_0, bus_address_in_1;
    logic [1:0]        bus_operation_in_0, bus_operation_in_1;
    logic              cache_hit_in_0, cache_hit_in_1;
    logic              mem_rd_en, mem_wr_en;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    snoop_bus_arbiter #(.GRANT_TIMEOUT(16), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req_core_0(req_core_0), .req_core_1(req_core_1),
        .grant_0(grant_0), .grant_1(grant_1),
        .bus_data_out_0(bus_data_out_0), .bus_data_out_1(bus_data_out_1),
        .bus_address_out_0(bus_address_out_0), .bus_address_out_1(bus_address_out_1),
        .bus_operation_out_0(bus_operation_out_0), .bus_operation_out_1(bus_operation_out_1),
        .cache_hit_out_0(cache_hit_out_0), .cache_hit_out_1(cache_hit_out_1),
        .flush_out_0(flush_out_0), .flush_out_1(flush_out_1),
        .bus_data_in_0(bus_data_in_0), .bus_data_in_1(bus_data_in_1),
        .bus_address_in_0(bus_address_in_0), .bus_address_in_1(bus_address_in_1),
        .bus_operation_in_0(bus_operation_in_0), .bus_operation_in_1(bus_operation_in_1),
        .cache_hit_in_0(cache_hit_in_0), .cache_hit_in_1(cache_hit_in_1),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Protocol monitors, sampled mid-cycle
    int rd_cycles = 0, wr_cycles = 0, both_grants = 0, rd_and_wr = 0;
    always @(negedge clk) begin
        if (mem_rd_en) rd_cycles++;
        if (mem_wr_en) wr_cycles++;
        if (grant_0 && grant_1) both_grants++;
        if (mem_rd_en && mem_wr_en) rd_and_wr++;
    end

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $error("FAIL sb_empty: observed %0h with no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                tests_failed++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rd0, wr0, granted;

    initial begin
        reset = 1'b1;
        req_core_0 = 1'b0; req_core_1 = 1'b0;
        bus_data_out_0 = '0; bus_data_out_1 = '0;
        bus_address_out_0 = '0; bus_address_out_1 = '0;
        bus_operation_out_0 = 2'b11; bus_operation_out_1 = 2'b11;
        cache_hit_out_0 = 1'b0; cache_hit_out_1 = 1'b0;
        flush_out_0 = 1'b0; flush_out_1 = 1'b0;
        mem_rdata = '0; mem_ready = 1'b0;

        // Reset state
        tick(); tick();
        push("rst_grant0", 64'd0);  check(64'(grant_0));
        push("rst_grant1", 64'd0);  check(64'(grant_1));
        push("rst_op0", 64'h3);     check(64'(bus_operation_in_0));
        push("rst_op1", 64'h3);     check(64'(bus_operation_in_1));
        push("rst_rd", 64'd0);      check(64'(mem_rd_en));
        push("rst_addr", 64'd0);    check(64'(mem_address));
        push("rst_data0", 64'd0);   check(64'(bus_data_in_0));
        reset = 1'b0;

        // Round robin tie: core 0 first, one IDLE cycle before core 1
        req_core_0 = 1'b1; req_core_1 = 1'b1;
        push("tie_grant0", 64'd1); push("tie_grant1", 64'd0);
        tick(); check(64'(grant_0)); check(64'(grant_1));
        repeat (5) tick();
        push("hold_grant0", 64'd1); check(64'(grant_0));
        req_core_0 = 1'b0;
        push("drop_grant0", 64'd0); push("gap_grant1", 64'd0);
        tick(); check(64'(grant_0)); check(64'(grant_1));
        push("next_grant1", 64'd1);
        tick(); check(64'(grant_1));
        req_core_1 = 1'b0;
        push("rel_grant1", 64'd0);
        tick(); check(64'(grant_1));
        tick();

        // BusRd miss serviced from memory
        rd0 = rd_cycles; wr0 = wr_cycles;
        req_core_0 = 1'b1; bus_address_out_0 = 32'h40; bus_operation_out_0 = 2'b00;
        push("rd_grant0", 64'd1);
        tick(); check(64'(grant_0));
        push("rd_fwd_op1", 64'h0); push("rd_fwd_addr1", 64'h40); push("rd_own_op0", 64'h3);
        tick(); check(64'(bus_operation_in_1)); check(64'(bus_address_in_1)); check(64'(bus_operation_in_0));
        push("rd_mem_rd", 64'd1); push("rd_mem_addr", 64'h40);
        tick(); check(64'(mem_rd_en)); check(64'(mem_address));
        tick(); tick();
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        push("rd_data0", 64'hDEADBEEF); push("rd_hit0", 64'd0); push("rd_rd_drop", 64'd0);
        tick(); check(64'(bus_data_in_0)); check(64'(cache_hit_in_0)); check(64'(mem_rd_en));
        mem_ready = 1'b0; mem_rdata = '0;
        push("rd_rd_cycles", 64'd3); check(64'(rd_cycles - rd0));
        req_core_0 = 1'b0; bus_operation_out_0 = 2'b11;
        push("rd_rel_grant0", 64'd0); push("rd_rel_op1", 64'h3);
        tick(); check(64'(grant_0)); check(64'(bus_operation_in_1));
        tick();
        push("rd_no_wr", 64'd0); check(64'(wr_cycles - wr0));

        // BusRd hit with flush from core 1
        rd0 = rd_cycles; wr0 = wr_cycles;
        req_core_0 = 1'b1; bus_address_out_0 = 32'h40; bus_operation_out_0 = 2'b00;
        cache_hit_out_1 = 1'b1; flush_out_1 = 1'b1; bus_data_out_1 = 32'h12345678;
        tick(); tick();
        push("fl_data0", 64'h12345678); push("fl_hit0", 64'd1); push("fl_wr", 64'd1);
        push("fl_waddr", 64'h40); push("fl_wdata", 64'h12345678);
        tick(); check(64'(bus_data_in_0)); check(64'(cache_hit_in_0)); check(64'(mem_wr_en));
        check(64'(mem_address)); check(64'(mem_wdata));
        push("fl_wr_drop", 64'd0); push("fl_hit_hold", 64'd1);
        tick(); check(64'(mem_wr_en)); check(64'(cache_hit_in_0));
        req_core_0 = 1'b0; bus_operation_out_0 = 2'b11;
        cache_hit_out_1 = 1'b0; flush_out_1 = 1'b0;
        push("fl_rel_hit0", 64'd0); push("fl_rel_grant0", 64'd0);
        tick(); check(64'(cache_hit_in_0)); check(64'(grant_0));
        tick();
        push("fl_wr_pulses", 64'd1); check(64'(wr_cycles - wr0));
        push("fl_no_rd", 64'd0);     check(64'(rd_cycles - rd0));

        // BusUpgr from core 1: no memory traffic
        rd0 = rd_cycles; wr0 = wr_cycles;
        req_core_1 = 1'b1; bus_address_out_1 = 32'h80; bus_operation_out_1 = 2'b01;
        push("up_grant1", 64'd1);
        tick(); check(64'(grant_1));
        push("up_fwd_op0", 64'h1); push("up_fwd_addr0", 64'h80);
        tick(); check(64'(bus_operation_in_0)); check(64'(bus_address_in_0));
        repeat (3) tick();
        push("up_hold_grant1", 64'd1); check(64'(grant_1));
        req_core_1 = 1'b0; bus_operation_out_1 = 2'b11;
        push("up_rel_grant1", 64'd0);
        tick(); check(64'(grant_1));
        tick();
        push("up_no_mem", 64'd0); check(64'((rd_cycles - rd0) + (wr_cycles - wr0)));

        // Grant timeout with competing request
        req_core_0 = 1'b1; req_core_1 = 1'b1;
        tick();
        granted = grant_0 ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (grant_0) granted++;
            else break;
        end
        push("to_granted", 64'd16); check(64'(granted));
        push("to_gap_grant1", 64'd0); check(64'(grant_1));
        push("to_next_grant1", 64'd1); push("to_next_grant0", 64'd0);
        tick(); check(64'(grant_1)); check(64'(grant_0));
        req_core_0 = 1'b0; req_core_1 = 1'b0;
        tick(); tick();

        // Reset during MEM aborts the read
        req_core_0 = 1'b1; bus_address_out_0 = 32'h100; bus_operation_out_0 = 2'b00;
        tick(); tick();
        push("rs_mem_rd", 64'd1);
        tick(); check(64'(mem_rd_en));
        tick();
        reset = 1'b1;
        push("rs_rd", 64'd0); push("rs_grant0", 64'd0); push("rs_op0", 64'h3); push("rs_op1", 64'h3);
        tick(); check(64'(mem_rd_en)); check(64'(grant_0)); check(64'(bus_operation_in_0)); check(64'(bus_operation_in_1));
        reset = 1'b0;
        push("rs_regrant0", 64'd1);
        tick(); check(64'(grant_0));
        req_core_0 = 1'b0; bus_operation_out_0 = 2'b11;
        tick(); tick();

        // Global invariants
        push("inv_both_grants", 64'd0); check(64'(both_grants));
        push("inv_rd_and_wr", 64'd0);   check(64'(rd_and_wr));
        push("inv_hit_in1", 64'd0);     check(64'(cache_hit_in_1));
        push("inv_data_in1", 64'd0);    check(64'(bus_data_in_1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
